// File: rtl/counter_display_driver.sv
// counter_display_driver: up/down counter of hex or BCD nibble digits, counted on rising edges of a debounced step.
// It also drives a registered 7-segment glyph for each digit, with optional blanking of leading zero digits.
module counter_display_driver #(
    parameter int DIGITS         = 2,
    parameter bit DECIMAL        = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rstN,
    input  logic                  i_step,
    input  logic                  i_down,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_loadValue,
    output logic [4*DIGITS-1:0]   o_count,
    output logic                  o_wrap,
    output logic [7*DIGITS-1:0]   o_segments
);
    localparam logic [3:0] MAX_DIGIT = DECIMAL ? 4'd9 : 4'd15;

    logic [4*DIGITS-1:0] count_q, count_d, step_count, load_clamped;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                wrap_q, wrap_d, step_prev_q, step_edge, ripple, blank;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    assign step_edge = i_step & ~step_prev_q;

    // Per-digit ripple; with MAX_DIGIT=15 this is plain binary arithmetic.
    always_comb begin
        ripple = 1'b1;
        step_count = count_q;
        load_clamped = i_loadValue;
        for (int n = 0; n < DIGITS; n++) begin
            step_count[4*n+:4] = !ripple ? count_q[4*n+:4] :
                                 i_down ? ((count_q[4*n+:4] == 4'd0) ? MAX_DIGIT : count_q[4*n+:4] - 4'd1) :
                                          ((count_q[4*n+:4] == MAX_DIGIT) ? 4'd0 : count_q[4*n+:4] + 4'd1);
            ripple = ripple & (i_down ? (count_q[4*n+:4] == 4'd0) : (count_q[4*n+:4] == MAX_DIGIT));
            load_clamped[4*n+:4] = (DECIMAL && i_loadValue[4*n+:4] > 4'd9) ? 4'd9 : i_loadValue[4*n+:4];
        end
    end

    assign count_d = i_clear ? '0 : i_load ? load_clamped : step_edge ? step_count : count_q;
    assign wrap_d  = ~i_clear & ~i_load & step_edge & ripple;

    // Scan from the top digit so blank tracks "this and all higher digits are zero".
    always_comb begin
        blank = 1'b1;
        seg_d = '0;
        for (int n = DIGITS - 1; n >= 0; n--) begin
            blank = blank & (count_q[4*n+:4] == 4'd0);
            seg_d[7*n+:7] = ((BLANK_LEADING && n > 0 && blank) ? 7'h00 : glyph(count_q[4*n+:4])) ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            seg_q       <= {7*DIGITS{SEG_ACTIVE_LOW}};
            step_prev_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
            step_prev_q <= i_step;
        end
    end

    assign o_count    = count_q;
    assign o_wrap     = wrap_q;
    assign o_segments = seg_q;
endmodule
